program_memory_loader: RTL and testbench
========================================

// Module: program_memory_loader
// PURPOSE
//  Responder end of the CPU instruction-fetch interface: a 16x8 program store that
//  returns {opcode,operand} for the program-counter address at each fetch.
//  Filled before run time through a 4-bit nibble loader port, hi nibble then lo nibble.
//  Sits beside the 4-bit CPU core on the same clock.
//  The CPU's ring counter issues the fetch and its instruction register captures instr.
// PARAMETERS
//  ADDR_W   4    address width (PC width); DEPTH = 2**ADDR_W = 16 words
//  NIB_W    4    loader nibble width; instruction width INSTR_W = 2*NIB_W = 8
// PORTS
//  clk1        in   1  single clock, all state on rising edge
//  MainClear   in   1  reset, synchronous, active-high
//  prg_nib     in   4  loader data nibble
//  prg_valid   in   1  loader nibble valid
//  prg_last    in   1  with lo-nibble beat: final word of program
//  prg_ready   out  1  loader may transfer (1 in load states only)
//  loaded      out  1  program complete, fetches are served
//  wr_ptr      out  4  next word address to be written
//  fetch_req   in   1  CPU fetch strobe (fetch T-state)
//  fetch_addr  in   4  PC value, sampled with fetch_req
//  fetch_ack   out  1  1-cycle pulse: instr valid
//  fetch_err   out  1  1-cycle pulse: fetch_req while not loaded
//  instr       out  8  {opcode[7:4], operand[3:0]}
// BEHAVIOUR
//  Reset: all outputs registered.
//   - State LOAD_HI, wr_ptr=0, loaded=0, prg_ready=1.
//   - fetch_ack=0, fetch_err=0, instr=8'h00 (NOP).
//   - All 16 words cleared to 8'h00, so unwritten words execute as NOP.
//  FSM LOAD_HI -> LOAD_LO -> LOAD_HI ... -> RUN. A beat is prg_valid&prg_ready.
//  LOAD_HI: beat captures prg_nib into hold reg -> LOAD_LO; prg_last ignored here.
//  LOAD_LO: beat writes mem[wr_ptr] <= {hold, prg_nib}; wr_ptr <= wr_ptr+1.
//   - Next state RUN if prg_last=1 or wr_ptr==15 (full), else LOAD_HI.
//  Full case: wr_ptr wraps to 0 on entering RUN; no further writes are possible.
//  RUN: prg_ready=0, loaded=1, prg_valid ignored.
//   - Leaving RUN only via MainClear (full reload).
//  Fetch, RUN: fetch_req=1 at edge N -> fetch_ack=1 and instr=mem[fetch_addr] at N+1.
//   - Fixed 1-cycle latency.
//   - Back-to-back fetch_req is served every cycle, fully pipelined.
//  No fetch_req: fetch_ack=0, instr holds its last value.
//  Fetch while not loaded: fetch_err pulses at N+1; fetch_ack=0; instr unchanged.
//  Write/read ordering: a fetch in the same cycle as the final write is impossible.
//   - loaded rises only after the write, so no bypass is needed.
//  MainClear mid-load or mid-run: next edge is the reset state and memory is cleared.
//   - A pending beat or fetch in that cycle is dropped (reset wins).
//  prg_valid with no beat accepted: no state change; prg_ready has no combinational path from inputs.
// STRUCTURE
//  Shared package (cpu4_pkg):
//   - Opcodes NOP=4'h0, ADD=4'h1, SUB=4'h2, OUT=4'h3, IN=4'h4, LOAD=4'h5.
//   - ADDR_W, INSTR_W.
//   - Loader state enum {LOAD_HI, LOAD_LO, RUN}.
//  Sub-module prog_mem_array:
//   - 16x8 flop array, synchronous write, synchronous clear, registered read port.
//   - Top holds the FSM, hold reg, wr_ptr, fetch_ack/fetch_err logic.
// TESTING
//  1 Reset then fetch_req addr 3 -> fetch_err=1 one cycle, fetch_ack=0, instr=00, prg_ready=1.
//  2 Load 3 words 0x15,0x12,0x30 (prg_last on 3rd lo beat).
//    -> loaded=1, wr_ptr=3, prg_ready=0.
//    -> Fetch addrs 0,1,2,7 back-to-back: acks on 4 consecutive cycles, instr=15,12,30,00.
//  3 Load 16 words 0x00..0xF0 without prg_last.
//    -> RUN after the 16th lo beat, wr_ptr=0.
//    -> Extra prg_valid ignored; fetch addr 15 -> instr=F0.
//  4 Stall prg_valid between hi and lo beats for 5 cycles, send 0x4 then 0x2.
//    -> mem[0]=0x42; hold survives the stall.
//  5 MainClear after hi nibble of word 2.
//    -> Next cycle: LOAD_HI, wr_ptr=0, loaded=0, instr=00.
//    -> Fetch of addr 0 after reload of 0x55 returns 55.
//  6 MainClear and fetch_req in the same cycle while in RUN -> no fetch_ack, instr=00, loaded=0.

Source files
------------

// File: rtl/cpu4_pkg.sv
// Shared definitions for the 4-bit CPU: opcodes, widths and the loader state type.
package cpu4_pkg;

    localparam int ADDR_W  = 4;
    localparam int NIB_W   = 4;
    localparam int INSTR_W = 2 * NIB_W;
    localparam int DEPTH   = 2 ** ADDR_W;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_OUT  = 4'h3;
    localparam logic [3:0] OP_IN   = 4'h4;
    localparam logic [3:0] OP_LOAD = 4'h5;

    // Loader progress: waiting for hi nibble, waiting for lo nibble, program complete.
    typedef enum logic [1:0] {
        LOAD_HI = 2'd0,
        LOAD_LO = 2'd1,
        RUN     = 2'd2
    } load_state_t;

    // Builds an instruction word {opcode, operand}.
    function automatic logic [INSTR_W-1:0] pack_instr(input logic [3:0] opcode,
                                                      input logic [3:0] operand);
        return {opcode, operand};
    endfunction

endpackage

// File: rtl/prog_mem_array.sv
// Flop-based program store: synchronous write, synchronous clear of every word,
// and a registered read port that holds its value when not enabled.
module prog_mem_array #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] words [DEPTH];
    logic [DATA_W-1:0] rd_data_reg;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_word
            logic [DATA_W-1:0] word_reg;

            // One storage word: clear has priority so a write in a reset cycle is dropped.
            always_ff @(posedge clk) begin
                if (clr) begin
                    word_reg <= '0;
                end else if (wr_en && (wr_addr == ADDR_W'(gi))) begin
                    word_reg <= wr_data;
                end
            end

            assign words[gi] = word_reg;
        end
    endgenerate

    // Registered read port; holds the last read word when no read is requested.
    always_ff @(posedge clk) begin
        if (clr) begin
            rd_data_reg <= '0;
        end else if (rd_en) begin
            rd_data_reg <= words[rd_addr];
        end
    end

    assign rd_data = rd_data_reg;

endmodule

// File: rtl/program_memory_loader.sv
// Program store with nibble loader: fills 16 words hi-nibble-first before run time,
// then serves CPU instruction fetches with a fixed one-cycle latency.
module program_memory_loader
    import cpu4_pkg::*;
#(
    parameter int ADDR_W = cpu4_pkg::ADDR_W,
    parameter int NIB_W  = cpu4_pkg::NIB_W
) (
    input  logic                 clk1,
    input  logic                 MainClear,
    input  logic [NIB_W-1:0]     prg_nib,
    input  logic                 prg_valid,
    input  logic                 prg_last,
    output logic                 prg_ready,
    output logic                 loaded,
    output logic [ADDR_W-1:0]    wr_ptr,
    input  logic                 fetch_req,
    input  logic [ADDR_W-1:0]    fetch_addr,
    output logic                 fetch_ack,
    output logic                 fetch_err,
    output logic [2*NIB_W-1:0]   instr
);

    localparam int IW = 2 * NIB_W;

    load_state_t       state_reg, state_next;
    logic [NIB_W-1:0]  hold_reg, hold_next;
    logic [ADDR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic              loaded_reg, prg_ready_reg;
    logic              fetch_ack_reg, fetch_err_reg;
    logic              beat;
    logic              mem_we;
    logic [IW-1:0]     mem_wdata;
    logic              mem_rd_en;

    // Loader state register.
    always_ff @(posedge clk1) begin
        if (MainClear) begin
            state_reg <= LOAD_HI;
        end else begin
            state_reg <= state_next;
        end
    end

    // Loader next-state, hold capture and memory write decode.
    always_comb begin
        state_next  = state_reg;
        hold_next   = hold_reg;
        wr_ptr_next = wr_ptr_reg;
        mem_we      = 1'b0;
        mem_wdata   = {hold_reg, prg_nib};
        beat        = prg_valid && prg_ready_reg;
        case (state_reg)
            LOAD_HI: begin
                if (beat) begin
                    hold_next  = prg_nib;
                    state_next = LOAD_LO;
                end
            end
            LOAD_LO: begin
                if (beat) begin
                    mem_we      = 1'b1;
                    wr_ptr_next = wr_ptr_reg + ADDR_W'(1);
                    // Last word of a full store also ends loading; the pointer wraps to 0.
                    if (prg_last || (wr_ptr_reg == {ADDR_W{1'b1}})) begin
                        state_next = RUN;
                    end else begin
                        state_next = LOAD_HI;
                    end
                end
            end
            RUN: begin
                state_next = RUN;
            end
            default: begin
                state_next = LOAD_HI;
            end
        endcase
    end

    // Loader datapath and registered status/fetch handshake outputs.
    always_ff @(posedge clk1) begin
        if (MainClear) begin
            hold_reg      <= '0;
            wr_ptr_reg    <= '0;
            loaded_reg    <= 1'b0;
            prg_ready_reg <= 1'b1;
            fetch_ack_reg <= 1'b0;
            fetch_err_reg <= 1'b0;
        end else begin
            hold_reg      <= hold_next;
            wr_ptr_reg    <= wr_ptr_next;
            loaded_reg    <= (state_next == RUN);
            prg_ready_reg <= (state_next != RUN);
            fetch_ack_reg <= fetch_req && loaded_reg;
            fetch_err_reg <= fetch_req && !loaded_reg;
        end
    end

    // Reads only happen once loaded, so the final write never collides with a fetch.
    assign mem_rd_en = fetch_req && loaded_reg;

    prog_mem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (IW)
    ) u_mem (
        .clk     (clk1),
        .clr     (MainClear),
        .wr_en   (mem_we),
        .wr_addr (wr_ptr_reg),
        .wr_data (mem_wdata),
        .rd_en   (mem_rd_en),
        .rd_addr (fetch_addr),
        .rd_data (instr)
    );

    assign prg_ready = prg_ready_reg;
    assign loaded    = loaded_reg;
    assign wr_ptr    = wr_ptr_reg;
    assign fetch_ack = fetch_ack_reg;
    assign fetch_err = fetch_err_reg;

endmodule

// File: tb/tb_program_memory_loader.sv
// Self-checking bench for program_memory_loader: directed table, hand-written
// corner sequences and a randomized run against a behavioural program-store model.
module tb_program_memory_loader;
    import cpu4_pkg::*;

    logic       clk1 = 1'b0;
    logic       MainClear;
    logic [3:0] prg_nib;
    logic       prg_valid;
    logic       prg_last;
    logic       prg_ready;
    logic       loaded;
    logic [3:0] wr_ptr;
    logic       fetch_req;
    logic [3:0] fetch_addr;
    logic       fetch_ack;
    logic       fetch_err;
    logic [7:0] instr;

    always #5 clk1 = ~clk1;

    program_memory_loader dut (
        .clk1       (clk1),
        .MainClear  (MainClear),
        .prg_nib    (prg_nib),
        .prg_valid  (prg_valid),
        .prg_last   (prg_last),
        .prg_ready  (prg_ready),
        .loaded     (loaded),
        .wr_ptr     (wr_ptr),
        .fetch_req  (fetch_req),
        .fetch_addr (fetch_addr),
        .fetch_ack  (fetch_ack),
        .fetch_err  (fetch_err),
        .instr      (instr)
    );

    int errors = 0;
    int checks = 0;

    // Behavioural model: a program image, a count of complete words and a pending hi nibble.
    logic [7:0] m_mem [16];
    int         m_words;
    bit         m_loaded;
    bit         m_have_hi;
    logic [3:0] m_hi;
    logic [7:0] m_instr;
    bit         m_ack;
    bit         m_err;

    typedef struct {
        bit         clr;
        bit         valid;
        bit         last;
        logic [3:0] nib;
        bit         freq;
        logic [3:0] faddr;
        bit         e_ack;
        bit         e_err;
        bit         e_loaded;
        logic [3:0] e_ptr;
        logic [7:0] e_instr;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
        m_words   = 0;
        m_loaded  = 0;
        m_have_hi = 0;
        m_hi      = 4'h0;
        m_instr   = 8'h00;
        m_ack     = 0;
        m_err     = 0;
    endtask

    // Applies one cycle of inputs, advances the model, and compares all outputs.
    task automatic step(input bit clr, input bit valid, input bit last, input logic [3:0] nib,
                        input bit freq, input logic [3:0] faddr, input string tag);
        MainClear  = clr;
        prg_valid  = valid;
        prg_last   = last;
        prg_nib    = nib;
        fetch_req  = freq;
        fetch_addr = faddr;
        @(posedge clk1);
        if (clr) begin
            model_reset();
        end else begin
            m_ack = 0;
            m_err = 0;
            if (freq) begin
                if (m_loaded) begin
                    m_ack   = 1;
                    m_instr = m_mem[faddr];
                end else begin
                    m_err = 1;
                end
            end
            if (valid && !m_loaded) begin
                if (!m_have_hi) begin
                    m_hi      = nib;
                    m_have_hi = 1;
                end else begin
                    m_mem[m_words % 16] = {m_hi, nib};
                    m_words++;
                    m_have_hi = 0;
                    if (last || m_words == 16) m_loaded = 1;
                end
            end
        end
        @(negedge clk1);
        $display("%s clr=%0b v=%0b l=%0b nib=%h f=%0b a=%h -> rdy=%0b ld=%0b ptr=%0d ack=%0b err=%0b instr=%02h",
                 tag, clr, valid, last, nib, freq, faddr,
                 prg_ready, loaded, wr_ptr, fetch_ack, fetch_err, instr);
        chk({tag, ".prg_ready"}, {7'b0, prg_ready}, {7'b0, !m_loaded});
        chk({tag, ".loaded"},    {7'b0, loaded},    {7'b0, m_loaded});
        chk({tag, ".wr_ptr"},    {4'b0, wr_ptr},    {4'b0, 4'(m_words % 16)});
        chk({tag, ".fetch_ack"}, {7'b0, fetch_ack}, {7'b0, m_ack});
        chk({tag, ".fetch_err"}, {7'b0, fetch_err}, {7'b0, m_err});
        chk({tag, ".instr"},     instr,             m_instr);
    endtask

    initial begin
        MainClear  = 1'b1;
        prg_valid  = 1'b0;
        prg_last   = 1'b0;
        prg_nib    = 4'h0;
        fetch_req  = 1'b0;
        fetch_addr = 4'h0;
        model_reset();
        @(negedge clk1);

        // Directed table: reset, fetch before load, 3-word load, back-to-back fetches.
        //              clr v l nib   f addr  ack err ld ptr  instr
        tbl.push_back('{1, 0, 0, 4'h0, 0, 4'h0, 0, 0, 0, 4'd0, 8'h00});
        tbl.push_back('{0, 0, 0, 4'h0, 1, 4'h3, 0, 1, 0, 4'd0, 8'h00});
        tbl.push_back('{0, 0, 0, 4'h0, 0, 4'h0, 0, 0, 0, 4'd0, 8'h00});
        tbl.push_back('{0, 1, 0, 4'h1, 0, 4'h0, 0, 0, 0, 4'd0, 8'h00});
        tbl.push_back('{0, 1, 0, 4'h5, 0, 4'h0, 0, 0, 0, 4'd1, 8'h00});
        tbl.push_back('{0, 1, 1, 4'h1, 0, 4'h0, 0, 0, 0, 4'd1, 8'h00});
        tbl.push_back('{0, 1, 0, 4'h2, 0, 4'h0, 0, 0, 0, 4'd2, 8'h00});
        tbl.push_back('{0, 1, 0, 4'h3, 0, 4'h0, 0, 0, 0, 4'd2, 8'h00});
        tbl.push_back('{0, 1, 1, 4'h0, 0, 4'h0, 0, 0, 1, 4'd3, 8'h00});
        tbl.push_back('{0, 0, 0, 4'h0, 1, 4'h0, 1, 0, 1, 4'd3, 8'h15});
        tbl.push_back('{0, 0, 0, 4'h0, 1, 4'h1, 1, 0, 1, 4'd3, 8'h12});
        tbl.push_back('{0, 0, 0, 4'h0, 1, 4'h2, 1, 0, 1, 4'd3, 8'h30});
        tbl.push_back('{0, 0, 0, 4'h0, 1, 4'h7, 1, 0, 1, 4'd3, 8'h00});
        tbl.push_back('{0, 0, 0, 4'h0, 1, 4'h1, 1, 0, 1, 4'd3, 8'h12});
        tbl.push_back('{0, 1, 1, 4'h9, 0, 4'h0, 0, 0, 1, 4'd3, 8'h12});

        for (int i = 0; i < tbl.size(); i++) begin
            string t;
            t = $sformatf("vec%0d", i);
            step(tbl[i].clr, tbl[i].valid, tbl[i].last, tbl[i].nib,
                 tbl[i].freq, tbl[i].faddr, t);
            chk({t, ".tbl_ack"},   {7'b0, fetch_ack}, {7'b0, tbl[i].e_ack});
            chk({t, ".tbl_err"},   {7'b0, fetch_err}, {7'b0, tbl[i].e_err});
            chk({t, ".tbl_ld"},    {7'b0, loaded},    {7'b0, tbl[i].e_loaded});
            chk({t, ".tbl_rdy"},   {7'b0, prg_ready}, {7'b0, !tbl[i].e_loaded});
            chk({t, ".tbl_ptr"},   {4'b0, wr_ptr},    {4'b0, tbl[i].e_ptr});
            chk({t, ".tbl_instr"}, instr,             tbl[i].e_instr);
        end

        // Full store: 16 words 0x00..0xF0 without prg_last.
        step(1, 0, 0, 4'h0, 0, 4'h0, "full.clr");
        for (int w = 0; w < 16; w++) begin
            step(0, 1, 0, 4'(w), 0, 4'h0, "full.hi");
            step(0, 1, 0, 4'h0, 0, 4'h0, "full.lo");
        end
        chk("full.loaded", {7'b0, loaded}, 8'h01);
        chk("full.wr_ptr", {4'b0, wr_ptr}, 8'h00);
        step(0, 1, 1, 4'hA, 0, 4'h0, "full.extra");
        step(0, 1, 0, 4'hB, 0, 4'h0, "full.extra");
        chk("full.ptr_after_extra", {4'b0, wr_ptr}, 8'h00);
        step(0, 0, 0, 4'h0, 1, 4'hF, "full.fetch15");
        chk("full.instr15", instr, 8'hF0);
        chk("full.ack15", {7'b0, fetch_ack}, 8'h01);

        // Stall between hi and lo nibble; hold must survive.
        step(1, 0, 0, 4'h0, 0, 4'h0, "stall.clr");
        step(0, 1, 0, 4'h4, 0, 4'h0, "stall.hi");
        for (int k = 0; k < 5; k++) step(0, 0, 1, 4'($urandom_range(0, 15)), 0, 4'h0, "stall.idle");
        step(0, 1, 1, 4'h2, 0, 4'h0, "stall.lo");
        step(0, 0, 0, 4'h0, 1, 4'h0, "stall.fetch");
        chk("stall.instr", instr, 8'h42);

        // Clear mid-load after the hi nibble of word 2, then reload 0x55.
        step(1, 0, 0, 4'h0, 0, 4'h0, "midload.clr");
        step(0, 1, 0, 4'h1, 0, 4'h0, "midload.hi");
        step(0, 1, 0, 4'h1, 0, 4'h0, "midload.lo");
        step(0, 1, 0, 4'h2, 0, 4'h0, "midload.hi");
        step(0, 1, 0, 4'h2, 0, 4'h0, "midload.lo");
        step(0, 1, 0, 4'h3, 0, 4'h0, "midload.hi");
        step(1, 1, 0, 4'h3, 0, 4'h0, "midload.clr2");
        chk("midload.ptr", {4'b0, wr_ptr}, 8'h00);
        chk("midload.loaded", {7'b0, loaded}, 8'h00);
        chk("midload.ready", {7'b0, prg_ready}, 8'h01);
        chk("midload.instr", instr, 8'h00);
        step(0, 1, 0, 4'h5, 0, 4'h0, "reload.hi");
        step(0, 1, 1, 4'h5, 0, 4'h0, "reload.lo");
        step(0, 0, 0, 4'h0, 1, 4'h0, "reload.fetch");
        chk("reload.instr", instr, 8'h55);
        step(0, 0, 0, 4'h0, 1, 4'h1, "reload.fetch1");
        chk("reload.cleared_word", instr, 8'h00);
        step(0, 0, 0, 4'h0, 1, 4'h0, "reload.fetch0");

        // Clear and fetch in the same cycle while running: reset wins.
        step(1, 0, 0, 4'h0, 1, 4'h0, "runclr");
        chk("runclr.ack", {7'b0, fetch_ack}, 8'h00);
        chk("runclr.instr", instr, 8'h00);
        chk("runclr.loaded", {7'b0, loaded}, 8'h00);

        // Randomized traffic against the model.
        for (int c = 0; c < 600; c++) begin
            step(($urandom % 60) == 0, ($urandom % 4) != 0, ($urandom % 6) == 0,
                 4'($urandom_range(0, 15)), ($urandom % 2) == 1,
                 4'($urandom_range(0, 15)), "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
